wb_stream_reader_ctrl: RTL and testbench

Wishbone master sequencer for the stream reader DMA. It is driven by the configuration block's enable, start_adr, buf_size and burst_size outputs. It fetches the buffer from memory as incrementing Wishbone bursts and pushes each returned word into the downstream stream FIFO. It reports busy and a transferred-word count back to the configuration block, whose interrupt fires on the falling edge of busy.

---
 rtl/wb_stream_reader_ctrl.sv | 138 +++++++++++++
 tb/tb_wb_stream_reader_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_reader_ctrl.sv
// Purpose: Wishbone read-burst master that streams a memory buffer into the downstream FIFO.
// Latency: first strobe two cycles after enable; words reach the FIFO combinationally in their ack cycle.
// Backpressure: a burst starts only once the FIFO has room for the whole burst; otherwise it waits with cyc low.
module wb_stream_reader_ctrl #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 6
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_wr,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic [WB_DW-1:0]     tx_cnt
);

    localparam int BPW = WB_DW / 8;
    localparam int WSH = $clog2(BPW);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [WB_AW-1:0] base_adr;
    logic [WB_AW-1:0] words;
    logic [WB_AW-1:0] burst_len;
    logic [WB_AW-1:0] cnt;
    logic [WB_AW-1:0] beat_cnt;
    logic [WB_AW-1:0] adr;

    logic [WB_AW-1:0] buf_words;
    logic [WB_AW-1:0] remaining;
    logic [WB_AW-1:0] blen;
    logic [WB_AW:0]   space;
    logic             start_ok;
    logic             go;
    logic             beat_ok;
    logic             beat_err;
    logic             last_beat;
    logic             done;

    // Buffer size in words and the length of the next burst (clipped to what is left).
    assign buf_words = buf_size >> WSH;
    assign remaining = words - cnt;
    assign blen      = (burst_len < remaining) ? burst_len : remaining;

    // Free FIFO slots, computed one bit wider so the full-depth value fits.
    assign space = ((WB_AW+1)'(1) << FIFO_AW) - {{(WB_AW-FIFO_AW){1'b0}}, fifo_cnt};

    assign start_ok  = (state == S_IDLE) && enable && (buf_words != '0);
    assign go        = (state == S_WAIT) && (space >= {1'b0, blen});
    assign beat_err  = (state == S_ACTIVE) && wbm_err_i;
    assign beat_ok   = (state == S_ACTIVE) && wbm_ack_i && !wbm_err_i;
    assign last_beat = beat_ok && (beat_cnt == WB_AW'(1));
    assign done      = last_beat && ((cnt + WB_AW'(1)) == words);

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state and bus control; cyc/stb are exactly the ACTIVE state so reset clears them at once.
    always_comb begin
        state_nxt = state;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_cti_o = 3'b000;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (go) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_cti_o = (beat_cnt == WB_AW'(1)) ? 3'b111 : 3'b010;
                if (beat_err)       state_nxt = S_IDLE;
                else if (last_beat) state_nxt = done ? S_IDLE : S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: latch config at start, load burst on launch, advance on each good ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            base_adr  <= '0;
            words     <= '0;
            burst_len <= '0;
            cnt       <= '0;
            beat_cnt  <= '0;
            adr       <= '0;
        end else begin
            if (start_ok) begin
                base_adr  <= start_adr;
                words     <= buf_words;
                burst_len <= (burst_size == '0) ? WB_AW'(1) : burst_size;
                cnt       <= '0;
            end
            if (go) begin
                adr      <= base_adr + (cnt << WSH);
                beat_cnt <= blen;
            end
            if (beat_ok) begin
                cnt      <= cnt + WB_AW'(1);
                adr      <= adr + WB_AW'(BPW);
                beat_cnt <= beat_cnt - WB_AW'(1);
            end
        end
    end

    assign wbm_adr_o = adr;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_bte_o = 2'b00;
    assign fifo_d    = wbm_dat_i;
    assign fifo_wr   = beat_ok;
    assign busy      = (state != S_IDLE);
    assign tx_cnt    = WB_DW'(cnt);

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Purpose: scoreboard bench for wb_stream_reader_ctrl with a Wishbone slave model.
// Latency: expected beats queued at stimulus time, checked by a monitor at each ack.
// Backpressure: fifo_cnt driven directly to exercise the FIFO-space wait.
module tb_wb_stream_reader_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic [31:0] fifo_d;
    logic        fifo_wr;
    logic [4:0]  fifo_cnt;
    logic        enable;
    logic [31:0] start_adr;
    logic [31:0] buf_size;
    logic [31:0] burst_size;
    logic        busy;
    logic [31:0] tx_cnt;

    wb_stream_reader_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i), .fifo_d(fifo_d), .fifo_wr(fifo_wr),
        .fifo_cnt(fifo_cnt), .enable(enable), .start_adr(start_adr),
        .buf_size(buf_size), .burst_size(burst_size), .busy(busy), .tx_cnt(tx_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ack_n = 0;
    time  last_ack_t = 0;
    time  err_t = 0;
    time  t_idle = 0;

    // Slave behaviour knobs (absolute beat indices).
    int slv_beat = 0;
    int slv_wait = 0;
    int wait_idx = -1;
    int wait_n   = 0;
    int err_idx  = -1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5AA5};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] sa, input int n, input int bl);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.adr = sa + 32'(4 * i);
            e.cti = (((i % bl) == bl - 1) || (i == n - 1)) ? 3'b111 : 3'b010;
            e.dat = mem_data(e.adr);
            exp_q.push_back(e);
        end
    endtask

    task automatic start(input logic [31:0] sa, input logic [31:0] bs, input logic [31:0] bz);
        start_adr  = sa;
        buf_size   = bs;
        burst_size = bz;
        enable     = 1'b1;
        @(posedge wb_clk_i);
        #1 enable = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            @(negedge wb_clk_i);
            #2;
            if (!busy) break;
        end
        t_idle = $time;
        if (i == maxc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", busy, maxc);
        end
    endtask

    // Wishbone slave: drives ack/err/data at the falling edge, with optional wait states and error.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (wbm_cyc_o && wbm_stb_o) begin
                if (slv_beat == wait_idx && slv_wait < wait_n) begin
                    slv_wait++;
                end else if (slv_beat == err_idx) begin
                    wbm_err_i = 1'b1;
                    slv_beat++;
                    slv_wait  = 0;
                end else begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = mem_data(wbm_adr_o);
                    slv_beat++;
                    slv_wait  = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every acked beat, checks hold-stability during waits.
    initial begin
        logic        held = 1'b0;
        logic [31:0] h_adr = '0;
        logic [2:0]  h_cti = '0;
        exp_t        e;
        forever begin
            @(negedge wb_clk_i);
            #2;
            if (wbm_cyc_o && wbm_stb_o && wbm_err_i) begin
                check("err_fifo_wr", 32'(fifo_wr), 32'd0);
                err_t = $time;
                held  = 1'b0;
            end else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: adr %h with empty scoreboard, expected no beat", wbm_adr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_adr", wbm_adr_o, e.adr);
                    check("beat_cti", 32'(wbm_cti_o), 32'(e.cti));
                    check("beat_fifo_wr", 32'(fifo_wr), 32'd1);
                    check("beat_fifo_d", fifo_d, e.dat);
                end
                ack_n++;
                last_ack_t = $time;
                held = 1'b0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (held) begin
                    check("wait_adr_stable", wbm_adr_o, h_adr);
                    check("wait_cti_stable", 32'(wbm_cti_o), 32'(h_cti));
                end
                held  = 1'b1;
                h_adr = wbm_adr_o;
                h_cti = wbm_cti_o;
            end else begin
                held = 1'b0;
            end
            if (fifo_wr && !(wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_fifo_wr: fifo_wr=1 without good ack, expected 0");
            end
        end
    end

    // Stimulus.
    initial begin
        int n0;
        wb_rst_i   = 1'b1;
        enable     = 1'b0;
        start_adr  = '0;
        buf_size   = '0;
        burst_size = '0;
        fifo_cnt   = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_cnt", tx_cnt, 32'd0);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_cti", 32'(wbm_cti_o), 32'd0);
        check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // 1: basic two-burst transfer
        push_exp(32'h1000, 8, 4);
        start(32'h1000, 32, 4);
        wait_idle(100);
        check("t1_tx_cnt", tx_cnt, 32'd8);
        check("t1_busy_fall", 32'(t_idle - last_ack_t), 32'd10);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: partial final burst
        push_exp(32'h1100, 10, 4);
        start(32'h1100, 40, 4);
        wait_idle(100);
        check("t2_tx_cnt", tx_cnt, 32'd10);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: FIFO backpressure (depth 16)
        fifo_cnt = 5'd14;
        push_exp(32'h2000, 4, 4);
        start(32'h2000, 16, 4);
        repeat (5) @(posedge wb_clk_i);
        #1;
        check("t3_wait_cyc", 32'(wbm_cyc_o), 32'd0);
        check("t3_wait_busy", 32'(busy), 32'd1);
        fifo_cnt = 5'd12;
        @(posedge wb_clk_i);
        #1;
        check("t3_go_cyc", 32'(wbm_cyc_o), 32'd1);
        check("t3_go_stb", 32'(wbm_stb_o), 32'd1);
        wait_idle(100);
        check("t3_tx_cnt", tx_cnt, 32'd4);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);
        fifo_cnt = '0;

        // 4: wait states on beat 1, error on beat 2
        wait_idx = slv_beat;
        wait_n   = 3;
        err_idx  = slv_beat + 1;
        push_exp(32'h2400, 1, 4);
        exp_q[0].cti = 3'b010;
        start(32'h2400, 16, 4);
        wait_idle(100);
        check("t4_busy_fall", 32'(t_idle - err_t), 32'd10);
        check("t4_tx_cnt", tx_cnt, 32'd1);
        check("t4_cyc", 32'(wbm_cyc_o), 32'd0);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);
        wait_idx = -1;
        err_idx  = -1;
        @(posedge wb_clk_i);
        #1;

        // 5a: zero-length buffer ignored
        start(32'h3000, 0, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            #2;
            check("t5a_busy", 32'(busy), 32'd0);
            check("t5a_cyc", 32'(wbm_cyc_o), 32'd0);
        end
        @(posedge wb_clk_i);
        #1;

        // 5b: burst_size 0 behaves as single-beat bursts
        push_exp(32'h3000, 2, 1);
        start(32'h3000, 8, 0);
        wait_idle(100);
        check("t5b_tx_cnt", tx_cnt, 32'd2);
        check("t5b_q_empty", 32'(exp_q.size()), 32'd0);
        @(posedge wb_clk_i);
        #1;

        // 5c: second enable and config change mid-transfer are ignored
        push_exp(32'h4000, 4, 2);
        start(32'h4000, 16, 2);
        @(posedge wb_clk_i);
        #1;
        start(32'h9000, 4, 1);
        wait_idle(100);
        check("t5c_tx_cnt", tx_cnt, 32'd4);
        check("t5c_q_empty", 32'(exp_q.size()), 32'd0);
        @(posedge wb_clk_i);
        #1;

        // 6: asynchronous reset mid-burst, then clean restart
        push_exp(32'h5000, 8, 8);
        n0 = ack_n;
        start(32'h5000, 32, 8);
        for (int i = 0; i < 50 && ack_n < n0 + 2; i++) begin
            @(negedge wb_clk_i);
            #2;
        end
        check("t6_two_acks", 32'(ack_n - n0), 32'd2);
        @(posedge wb_clk_i);
        #3 wb_rst_i = 1'b1;
        #1;
        check("t6_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("t6_rst_stb", 32'(wbm_stb_o), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_tx_cnt", tx_cnt, 32'd0);
        exp_q.delete();
        @(posedge wb_clk_i);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        push_exp(32'h5000, 4, 4);
        start(32'h5000, 16, 4);
        wait_idle(100);
        check("t6_tx_cnt", tx_cnt, 32'd4);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
